pif_to_posit_enc: RTL and testbench
===================================

Name: pif_to_posit_enc

Overview:
- Return path of the PPU arithmetic datapath: consumes the {sign, total exponent, full fraction} result of the core operation stage and encodes it back into an N-bit posit.
- Covers regime/exponent packing, round-to-nearest-even, saturation, two's-complement negation and zero/NaR special cases.
- Two-stage pipeline with valid/ready handshake on both sides; sits between the ops stage and the PPU output register.

Parameters:
- N, 16, posit width in bits (>= 8).
- ES, 1, posit exponent field width (0..3).
- FRAC_FULL_SIZE, 28, width of the incoming fraction; MSB-aligned, hidden bit excluded.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sign  in  1  result sign
- in_te  in  TE_SIZE  signed total exponent (k*2^ES + e)
- in_frac_full  in  FRAC_FULL_SIZE  fraction bits, MSB = weight 1/2
- in_is_zero  in  1  result is exactly zero
- in_is_nar  in  1  result is NaR (dominates in_is_zero)
- out_valid  out  1  posit valid
- out_ready  in  1  downstream accepts
- out_posit  out  N  encoded posit

Behaviour:
- One clock. Reset is synchronous and active-high; clk and rst as listed.
- Reset: out_valid=0, out_posit=0, both stage valids=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards in-flight beats; no output for them.
- Transfer occurs when valid && ready on the same edge.
- Latency 2 cycles, input accept edge to out_valid high, when unstalled. Throughput 1 beat/cycle.
- in_ready = !s1_valid || s2_advance. s2_advance = !out_valid || out_ready.
- Stall: out_posit/out_valid held stable while out_valid && !out_ready. No beat dropped or duplicated.
- Stage 1 (s1):
  - k = in_te >>> ES (arithmetic); e = in_te[ES-1:0].
  - Clamp k to [-(N-2), N-2]. Record sat_hi/sat_lo if clamped.
  - Regime: k>=0 gives k+1 ones then a zero; k<0 gives -k zeros then a one.
  - Build an unsigned body {regime, e, frac} left-aligned in a register of width N-1+3.
  - Capture guard bit and sticky (OR of all remaining bits, including truncated frac).
- Stage 2 (s2):
  - Take the top N-1 body bits as mag; lsb = mag[0].
  - Round up iff guard && (sticky || lsb).
  - If rounding overflows into the sign position, or sat_hi: mag = maxpos (all ones).
  - If mag==0 or sat_lo: mag = minpos (1). Nonzero finite input never encodes to 0 or NaR.
  - out_posit = sign ? -{0,mag} : {0,mag} (N-bit two's complement).
- Specials bypass rounding: is_nar gives 1 followed by N-1 zeros; else is_zero gives all zeros. Sign is ignored for both.
- Exponent bits pushed past the word by a long regime are truncated and contribute to guard/sticky.

Optional Feature:
- Macro PPU_ENC_SAT_CNT_EN.
- When defined: extra output sat_count[31:0].
  - Increments by 1 on every out transfer whose beat was saturated (sat_hi, sat_lo, or rounding overflow).
  - Wraps at 2^32-1 to 0; cleared by rst.
- When undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Shared package (ppu_pkg) holds:
  - TE_SIZE = ES+$clog2(N)+2.
  - FRAC_FULL_SIZE default.
  - Posit constants ZERO, NAR, MAXPOS, MINPOS as functions of N.
  - A packed struct for the s1->s2 payload: sign, body, guard, sticky, sat flags, special flags.
- One sub-module, posit_round_rne: combinational; inputs mag/guard/sticky/sat flags; outputs rounded, saturated magnitude. Reused by the future conversion unit.

Test Plan (N=16, ES=1):
- te=0, frac=0, sign=0 -> 0x4000 two cycles after accept; sign=1 -> 0xC000.
- te=1, frac=0 -> 0x5000. te=-1, frac=0 -> 0x3000.
- te=0, frac=only the bit just below the 12 kept bits (tie) -> 0x4000 (even). Same plus any lower bit set -> 0x4001.
- te=40 -> 0x7FFF (maxpos). te=-40 -> 0x0001; with sign=1 -> 0xFFFF.
- is_zero=1 -> 0x0000. is_nar=1 with is_zero=1 -> 0x8000.
- Stream 5 back-to-back beats with out_ready low for 3 cycles mid-stream:
  - in_ready drops once both stages are full.
  - All 5 posits emerge in order; out_posit stable during the stall.
  - rst asserted mid-stream -> out_valid=0 next cycle.
  - With PPU_ENC_SAT_CNT_EN: sat_count matches the number of saturated beats.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared posit sizing helpers and special-value constants
package ppu_pkg;
    localparam int FRAC_FULL_SIZE_DEF = 28;
    function automatic int te_size(input int n, input int es);
        return es + $clog2(n) + 2;
    endfunction
    function automatic logic [63:0] posit_nar(input int n);
        return 64'd1 << (n - 1);
    endfunction
    function automatic logic [63:0] posit_zero(input int n);
        return posit_nar(n) >> n;
    endfunction
    function automatic logic [63:0] posit_maxpos(input int n);
        return posit_nar(n) - 64'd1;
    endfunction
    function automatic logic [63:0] posit_minpos(input int n);
        return posit_nar(n) >> (n - 1);
    endfunction
endpackage

// File: rtl/posit_round_rne.sv
// posit_round_rne: round-to-nearest-even of a posit magnitude, saturating to maxpos/minpos
module posit_round_rne import ppu_pkg::*; #(
    parameter int N = 16
) (
    input  logic [N-2:0] mag_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    input  logic         sat_hi_i,
    input  logic         sat_lo_i,
    output logic [N-2:0] mag_o,
    output logic         sat_o
);
    localparam logic [N-2:0] MAG_MAX = (N-1)'(posit_maxpos(N));
    localparam logic [N-2:0] MAG_MIN = (N-1)'(posit_minpos(N));
    logic [N-1:0] sum;
    logic         ovf;
    always_comb begin
        sum   = {1'b0, mag_i} + N'(guard_i && (sticky_i || mag_i[0]));
        ovf   = sum[N-1];
        mag_o = (sat_hi_i || ovf) ? MAG_MAX :
                (sat_lo_i || sum[N-2:0] == '0) ? MAG_MIN : sum[N-2:0];
        sat_o = sat_hi_i || sat_lo_i || ovf;
    end
endmodule

// File: rtl/pif_to_posit_enc.sv
// pif_to_posit_enc: two-stage {sign, te, frac} to posit encoder; PPU_ENC_SAT_CNT_EN adds sat_count
module pif_to_posit_enc import ppu_pkg::*; #(
    parameter int N              = 16,
    parameter int ES             = 1,
    parameter int FRAC_FULL_SIZE = FRAC_FULL_SIZE_DEF,
    localparam int TE_SIZE       = te_size(N, ES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic signed [TE_SIZE-1:0] in_te,
    input  logic [FRAC_FULL_SIZE-1:0] in_frac_full,
    input  logic                      in_is_zero,
    input  logic                      in_is_nar,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              out_posit
`ifdef PPU_ENC_SAT_CNT_EN
    ,
    output logic [31:0]               sat_count
`endif
);
    localparam int KMAX = N - 2;
    localparam int BW   = N + 2;
    localparam int W    = ES + FRAC_FULL_SIZE + BW;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] TOP  = {1'b1, {(W-1){1'b0}}};
    localparam logic [N-1:0] NAR  = N'(posit_nar(N));
    localparam logic [N-1:0] ZERO = N'(posit_zero(N));

    typedef struct packed {
        logic         sign;
        logic [N-2:0] body;
        logic         guard;
        logic         sticky;
        logic         sat_hi;
        logic         sat_lo;
        logic         is_zero;
        logic         is_nar;
    } s1_t;

    s1_t          s1_d, s1_q;
    logic         s1_valid_q, out_valid_q, s2_adv, sat_r, sat_d;
    logic [N-1:0] out_posit_q, posit_d, pos_mag;
    logic [N-2:0] mag_r;
    logic [W-1:0] tail, regime, body_full;
    int           k, kc, r_len;

    assign s2_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign out_valid = out_valid_q;
    assign out_posit = out_posit_q;

    // Zero padding below the fraction absorbs the regime shift, so only zeros fall off the end.
    always_comb begin
        k              = int'(in_te >>> ES);
        kc             = (k > KMAX) ? KMAX : (k < -KMAX) ? -KMAX : k;
        r_len          = (kc >= 0) ? kc + 2 : 1 - kc;
        tail           = W'({in_te, in_frac_full, {BW{1'b0}}});
        regime         = (kc >= 0) ? ~(ONES >> (r_len - 1)) : (TOP >> (r_len - 1));
        body_full      = (tail >> r_len) | regime;
        s1_d.sign      = in_sign;
        s1_d.body      = body_full[W-1 -: N-1];
        s1_d.guard     = body_full[W-N];
        s1_d.sticky    = |body_full[W-N-1:0];
        s1_d.sat_hi    = k > KMAX;
        s1_d.sat_lo    = k < -KMAX;
        s1_d.is_zero   = in_is_zero;
        s1_d.is_nar    = in_is_nar;
    end

    posit_round_rne #(.N(N)) u_round (
        .mag_i    (s1_q.body),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .sat_hi_i (s1_q.sat_hi),
        .sat_lo_i (s1_q.sat_lo),
        .mag_o    (mag_r),
        .sat_o    (sat_r)
    );

    always_comb begin
        pos_mag = {1'b0, mag_r};
        posit_d = s1_q.is_nar ? NAR : s1_q.is_zero ? ZERO : s1_q.sign ? -pos_mag : pos_mag;
        sat_d   = sat_r && !s1_q.is_nar && !s1_q.is_zero;
    end

`ifdef PPU_ENC_SAT_CNT_EN
    logic        out_sat_q;
    logic [31:0] sat_count_q;
    assign sat_count = sat_count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            if (s2_adv && s1_valid_q)
                out_sat_q <= sat_d;
            if (out_valid_q && out_ready && out_sat_q)
                sat_count_q <= sat_count_q + 32'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid)
                    s1_q <= s1_d;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q)
                    out_posit_q <= posit_d;
            end
        end
    end
endmodule

// File: tb/tb_pif_to_posit_enc.sv
// tb_pif_to_posit_enc: directed checks of the N=16, ES=1 posit encoder
module tb_pif_to_posit_enc;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sign = 1'b0;
    logic signed [6:0]  in_te = '0;
    logic [27:0]        in_frac_full = '0;
    logic               in_is_zero = 1'b0;
    logic               in_is_nar = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [15:0]        out_posit;
`ifdef PPU_ENC_SAT_CNT_EN
    logic [31:0]        sat_count;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pif_to_posit_enc #(.N(16), .ES(1), .FRAC_FULL_SIZE(28)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_te        (in_te),
        .in_frac_full (in_frac_full),
        .in_is_zero   (in_is_zero),
        .in_is_nar    (in_is_nar),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_posit    (out_posit)
`ifdef PPU_ENC_SAT_CNT_EN
        ,
        .sat_count    (sat_count)
`endif
    );

    typedef struct {
        logic        s;
        int          te;
        logic [27:0] f;
        logic        z;
        logic        n;
        logic [15:0] exp;
    } vec_t;

    task automatic drive(input vec_t v);
        in_sign = v.s;
        in_te = 7'(v.te);
        in_frac_full = v.f;
        in_is_zero = v.z;
        in_is_nar = v.n;
    endtask

    // One beat through an otherwise idle pipe; lat counts edges from the accept edge.
    task automatic run_beat(input vec_t v, output logic [15:0] p, output int lat);
        drive(v);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        p = out_posit;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_posit !== 16'h0000) begin n_err++; $display("FAIL reset_posit: got %h want 0000", out_posit); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef PPU_ENC_SAT_CNT_EN
        n_cmp++;
        if (sat_count !== 32'd0) begin n_err++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
`endif
    endtask

    task automatic test_encode();
        vec_t v[19];
        logic [15:0] p;
        int lat;
        v[0]  = '{1'b0,   0, 28'h0000000, 1'b0, 1'b0, 16'h4000};
        v[1]  = '{1'b1,   0, 28'h0000000, 1'b0, 1'b0, 16'hC000};
        v[2]  = '{1'b0,   1, 28'h0000000, 1'b0, 1'b0, 16'h5000};
        v[3]  = '{1'b0,  -1, 28'h0000000, 1'b0, 1'b0, 16'h3000};
        v[4]  = '{1'b0,   3, 28'h8000000, 1'b0, 1'b0, 16'h6C00};
        v[5]  = '{1'b1,   3, 28'h8000000, 1'b0, 1'b0, 16'h9400};
        v[6]  = '{1'b0,   0, 28'h0008000, 1'b0, 1'b0, 16'h4000};
        v[7]  = '{1'b0,   0, 28'h0008001, 1'b0, 1'b0, 16'h4001};
        v[8]  = '{1'b0,   0, 28'h0018000, 1'b0, 1'b0, 16'h4002};
        v[9]  = '{1'b0,  40, 28'h0000000, 1'b0, 1'b0, 16'h7FFF};
        v[10] = '{1'b0, -40, 28'h0000000, 1'b0, 1'b0, 16'h0001};
        v[11] = '{1'b1, -40, 28'h0000000, 1'b0, 1'b0, 16'hFFFF};
        v[12] = '{1'b0,  28, 28'h0000000, 1'b0, 1'b0, 16'h7FFF};
        v[13] = '{1'b0, -28, 28'h0000000, 1'b0, 1'b0, 16'h0001};
        v[14] = '{1'b0, -27, 28'h0000000, 1'b0, 1'b0, 16'h0002};
        v[15] = '{1'b0,   5, 28'h0000000, 1'b1, 1'b0, 16'h0000};
        v[16] = '{1'b1,   5, 28'h0000000, 1'b1, 1'b0, 16'h0000};
        v[17] = '{1'b0,   0, 28'h0000000, 1'b1, 1'b1, 16'h8000};
        v[18] = '{1'b1,  40, 28'h0000000, 1'b0, 1'b1, 16'h8000};
        foreach (v[i]) begin
            run_beat(v[i], p, lat);
            n_cmp++;
            if (p !== v[i].exp) begin n_err++; $display("FAIL encode[%0d]: got %h want %h", i, p, v[i].exp); end
            n_cmp++;
            if (lat !== 2) begin n_err++; $display("FAIL latency[%0d]: got %0d want 2", i, lat); end
        end
`ifdef PPU_ENC_SAT_CNT_EN
        n_cmp++;
        if (sat_count !== 32'd3) begin n_err++; $display("FAIL sat_count_encode: got %0d want 3", sat_count); end
`endif
    endtask

    task automatic test_back_to_back();
        vec_t v[5];
        int ii = 0;
        int oi = 0;
        int cyc = 0;
        bit holding = 0;
        bit saw_block = 0;
        bit fire_in;
        logic [15:0] held = '0;
        v[0] = '{1'b0,   0, 28'h0, 1'b0, 1'b0, 16'h4000};
        v[1] = '{1'b0,   1, 28'h0, 1'b0, 1'b0, 16'h5000};
        v[2] = '{1'b0,  -1, 28'h0, 1'b0, 1'b0, 16'h3000};
        v[3] = '{1'b0,  40, 28'h0, 1'b0, 1'b0, 16'h7FFF};
        v[4] = '{1'b1, -40, 28'h0, 1'b0, 1'b0, 16'hFFFF};
        while (oi < 5 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid = ii < 5;
            if (ii < 5) drive(v[ii]);
            @(negedge clk);
            if (holding) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_posit !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got %b/%h want 1/%h", out_valid, out_posit, held);
                end
            end
            holding = out_valid && !out_ready;
            held = out_posit;
            if (in_valid && !in_ready) saw_block = 1;
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_posit !== v[oi].exp) begin n_err++; $display("FAIL stream[%0d]: got %h want %h", oi, out_posit, v[oi].exp); end
                oi++;
            end
            @(posedge clk); #1;
            if (fire_in) ii++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (oi !== 5) begin n_err++; $display("FAIL stream_count: got %0d want 5", oi); end
        n_cmp++;
        if (saw_block !== 1'b1) begin n_err++; $display("FAIL stream_backpressure: got %b want 1", saw_block); end
`ifdef PPU_ENC_SAT_CNT_EN
        n_cmp++;
        if (sat_count !== 32'd5) begin n_err++; $display("FAIL sat_count_stream: got %0d want 5", sat_count); end
`endif
    endtask

    task automatic test_reset_midstream();
        bit seen = 0;
        vec_t v;
        v = '{1'b0, 0, 28'h0, 1'b0, 1'b0, 16'h4000};
        drive(v);
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_posit !== 16'h0000) begin n_err++; $display("FAIL midreset_posit: got %h want 0000", out_posit); end
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_flush: got %b want 0", seen); end
`ifdef PPU_ENC_SAT_CNT_EN
        n_cmp++;
        if (sat_count !== 32'd0) begin n_err++; $display("FAIL midreset_sat_count: got %0d want 0", sat_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_encode();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
